// File: rtl/lut_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lut_bram_port_arbiter
// Brief    : Round-robin arbiter sharing one no-change, 2-cycle-latency LUT
//            BRAM port between the coefficient loader (req0) and the
//            approximation datapath (req1). Registers the port command,
//            tracks in-flight reads and steers each read result back to
//            the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module lut_bram_port_arbiter #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  // Requester 0: coefficient loader
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic [ADDR_LINES-1:0] req0_addr_i,
  input  logic [RAM_WIDTH-1:0]  req0_wdata_i,

  // Requester 1: approximation datapath
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic [ADDR_LINES-1:0] req1_addr_i,
  input  logic [RAM_WIDTH-1:0]  req1_wdata_i,

  // Read responses (data shared, qualified per requester)
  output logic                  rsp0_valid_o,
  output logic                  rsp1_valid_o,
  output logic [RAM_WIDTH-1:0]  rsp_data_o,

  // BRAM port
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_LINES-1:0] bram_addr_o,
  output logic [RAM_WIDTH-1:0]  bram_din_o,
  output logic                  bram_regce_o,
  output logic                  bram_rstn_o,
  input  logic [RAM_WIDTH-1:0]  bram_dout_i
);

  // Requester identifiers carried down the read pipeline
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Round-robin priority pointer: names the requester that wins a tie
  logic                  ptr_q,       ptr_d;

  // Registered BRAM port command
  logic                  cmd_en_q,    cmd_en_d;
  logic                  cmd_we_q,    cmd_we_d;
  logic [ADDR_LINES-1:0] cmd_addr_q,  cmd_addr_d;
  logic [RAM_WIDTH-1:0]  cmd_din_q,   cmd_din_d;
  logic                  cmd_id_q,    cmd_id_d;

  // Read tracking pipeline, aligned to the BRAM's two internal registers
  logic                  s1_valid_q,  s1_valid_d;
  logic                  s1_id_q,     s1_id_d;
  logic                  s2_valid_q,  s2_valid_d;
  logic                  s2_id_q,     s2_id_d;

  // Grant decode
  logic                  grant0;
  logic                  grant1;
  logic                  xfer;
  logic                  grant_id;

  // Grant: a lone valid always wins; on a tie the pointer decides
  always_comb begin
    grant0   = req0_valid_i & (~req1_valid_i | (ptr_q == ID_REQ0));
    grant1   = req1_valid_i & (~req0_valid_i | (ptr_q == ID_REQ1));
    xfer     = grant0 | grant1;
    grant_id = grant1 ? ID_REQ1 : ID_REQ0;
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Next state: pointer update, command capture and read pipeline advance
  always_comb begin
    ptr_d      = ptr_q;
    cmd_en_d   = 1'b0;
    cmd_we_d   = 1'b0;
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    cmd_id_d   = cmd_id_q;

    if (xfer) begin
      // After a transfer the loser of this round gets priority next time
      ptr_d    = ~grant_id;
      cmd_en_d = 1'b1;
      cmd_id_d = grant_id;
      if (grant1) begin
        cmd_we_d   = req1_we_i;
        cmd_addr_d = req1_addr_i;
        cmd_din_d  = req1_wdata_i;
      end else begin
        cmd_we_d   = req0_we_i;
        cmd_addr_d = req0_addr_i;
        cmd_din_d  = req0_wdata_i;
      end
    end

    // Only reads occupy the pipeline; writes never produce a response
    s1_valid_d = cmd_en_q & ~cmd_we_q;
    s1_id_d    = cmd_id_q;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  // State registers; reset drops every in-flight read immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= ID_REQ0;
      cmd_en_q   <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      cmd_id_q   <= ID_REQ0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= ID_REQ0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= ID_REQ0;
    end else begin
      ptr_q      <= ptr_d;
      cmd_en_q   <= cmd_en_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_din_q  <= cmd_din_d;
      cmd_id_q   <= cmd_id_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
    end
  end

  // BRAM port drive. The output register is clocked by s1 so that it
  // captures the internal read register exactly one cycle after the read.
  assign bram_en_o    = cmd_en_q;
  assign bram_we_o    = cmd_we_q;
  assign bram_addr_o  = cmd_addr_q;
  assign bram_din_o   = cmd_din_q;
  assign bram_regce_o = s1_valid_q;
  assign bram_rstn_o  = ~rst_i;

  // Response steering: data is a passthrough, s2 says who owns it
  assign rsp0_valid_o = s2_valid_q & (s2_id_q == ID_REQ0);
  assign rsp1_valid_o = s2_valid_q & (s2_id_q == ID_REQ1);
  assign rsp_data_o   = bram_dout_i;

endmodule
`default_nettype wire

// File: tb/tb_lut_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_bram_port_arbiter
// Brief    : Self-checking bench for lut_bram_port_arbiter with a behavioural
//            no-change, 2-cycle-latency BRAM behind the shared port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_bram_port_arbiter;

  localparam int RAM_WIDTH  = 32;
  localparam int ADDR_LINES = 4;
  localparam int DEPTH      = 1 << ADDR_LINES;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  req0_valid_i = 1'b0, req0_we_i = 1'b0;
  logic                  req1_valid_i = 1'b0, req1_we_i = 1'b0;
  logic [ADDR_LINES-1:0] req0_addr_i = '0, req1_addr_i = '0;
  logic [RAM_WIDTH-1:0]  req0_wdata_i = '0, req1_wdata_i = '0;
  logic                  req0_ready_o, req1_ready_o;
  logic                  rsp0_valid_o, rsp1_valid_o;
  logic [RAM_WIDTH-1:0]  rsp_data_o;
  logic                  bram_en_o, bram_we_o, bram_regce_o, bram_rstn_o;
  logic [ADDR_LINES-1:0] bram_addr_o;
  logic [RAM_WIDTH-1:0]  bram_din_o;
  logic [RAM_WIDTH-1:0]  bram_dout_i;

  lut_bram_port_arbiter #(.RAM_WIDTH(RAM_WIDTH), .ADDR_LINES(ADDR_LINES)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o), .rsp_data_o(rsp_data_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_din_o(bram_din_o), .bram_regce_o(bram_regce_o), .bram_rstn_o(bram_rstn_o),
    .bram_dout_i(bram_dout_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural BRAM port: no-change mode, internal read reg + output reg
  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [RAM_WIDTH-1:0] ram_q;
  logic [RAM_WIDTH-1:0] out_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_q = '0;
    out_q = '0;
  end
  always @(posedge clk_i) begin
    if (bram_en_o) begin
      if (bram_we_o) mem[bram_addr_o] <= bram_din_o;
      else           ram_q <= mem[bram_addr_o];
    end
    if (!bram_rstn_o)      out_q <= '0;
    else if (bram_regce_o) out_q <= ram_q;
  end
  assign bram_dout_i = out_q;

  // Bookkeeping
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic                  v0;
    logic                  we0;
    logic [ADDR_LINES-1:0] a0;
    logic [RAM_WIDTH-1:0]  d0;
    logic                  v1;
    logic                  we1;
    logic [ADDR_LINES-1:0] a1;
    logic [RAM_WIDTH-1:0]  d1;
    int                    g;   // expected grant: 0 none, 1 req0, 2 req1
  } vec_t;

  typedef struct {
    int                   id;
    logic [RAM_WIDTH-1:0] data;
    int                   due;
  } rsp_t;

  rsp_t                  exp_q[$];
  logic [RAM_WIDTH-1:0]  exp_mem [DEPTH];
  logic [ADDR_LINES-1:0] last_addr = '0;
  logic [RAM_WIDTH-1:0]  last_din  = '0;

  function automatic vec_t mk(input logic v0, input logic we0, input int a0,
                              input logic [RAM_WIDTH-1:0] d0,
                              input logic v1, input logic we1, input int a1,
                              input logic [RAM_WIDTH-1:0] d1, input int g);
    vec_t r;
    r.v0 = v0; r.we0 = we0; r.a0 = ADDR_LINES'(a0); r.d0 = d0;
    r.v1 = v1; r.we1 = we1; r.a1 = ADDR_LINES'(a1); r.d1 = d1;
    r.g  = g;
    return r;
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 0);
  endfunction

  // Response monitor: every cycle, the expected response (or silence)
  logic                 m_e0, m_e1;
  logic [RAM_WIDTH-1:0] m_ed;
  rsp_t                 m_item;
  always @(negedge clk_i) begin
    m_e0 = 1'b0; m_e1 = 1'b0; m_ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      m_item = exp_q.pop_front();
      m_e0   = (m_item.id == 0);
      m_e1   = (m_item.id == 1);
      m_ed   = m_item.data;
    end
    checks++;
    if (rsp0_valid_o !== m_e0 || rsp1_valid_o !== m_e1 ||
        ((m_e0 | m_e1) && rsp_data_o !== m_ed)) begin
      errors++;
      $display("FAIL rsp cyc=%0d: got v0=%b v1=%b data=%h, want v0=%b v1=%b data=%h",
               cyc, rsp0_valid_o, rsp1_valid_o, rsp_data_o, m_e0, m_e1, m_ed);
    end
  end

  // One cycle: drive at posedge+1, check ready at negedge, command after edge
  task automatic step(input vec_t v);
    int   due;
    logic exp_we;
    req0_valid_i = v.v0; req0_we_i = v.we0; req0_addr_i = v.a0; req0_wdata_i = v.d0;
    req1_valid_i = v.v1; req1_we_i = v.we1; req1_addr_i = v.a1; req1_wdata_i = v.d1;
    #4;
    checks++;
    if (req0_ready_o !== (v.g == 1) || req1_ready_o !== (v.g == 2)) begin
      errors++;
      $display("FAIL ready cyc=%0d: got r0=%b r1=%b, want grant %0d",
               cyc, req0_ready_o, req1_ready_o, v.g);
    end
    due    = cyc + 3;
    exp_we = 1'b0;
    if (v.g == 1) begin
      exp_we = v.we0; last_addr = v.a0; last_din = v.d0;
      if (v.we0) exp_mem[v.a0] = v.d0;
      else exp_q.push_back('{0, exp_mem[v.a0], due});
    end else if (v.g == 2) begin
      exp_we = v.we1; last_addr = v.a1; last_din = v.d1;
      if (v.we1) exp_mem[v.a1] = v.d1;
      else exp_q.push_back('{1, exp_mem[v.a1], due});
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (bram_en_o !== (v.g != 0) || bram_we_o !== exp_we ||
        bram_addr_o !== last_addr || bram_din_o !== last_din) begin
      errors++;
      $display("FAIL cmd cyc=%0d: got en=%b we=%b addr=%h din=%h, want en=%b we=%b addr=%h din=%h",
               cyc, bram_en_o, bram_we_o, bram_addr_o, bram_din_o,
               (v.g != 0), exp_we, last_addr, last_din);
    end
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    // Vector table: single read, contention, write->read, streaming
    vecs.push_back(mk(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, '0, 1));
    vecs.push_back(mk(1, 0, 3, '0, 0, 0, 0, '0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(idle());
    vecs.push_back(mk(0, 0, 0, '0, 1, 0, 5, '0, 2));          // pointer -> 0
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 0, 1, '0, 1, 0, 2, '0, (i % 2 == 0) ? 1 : 2));
    for (int i = 0; i < 3; i++) vecs.push_back(idle());
    vecs.push_back(mk(1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, '0, 1));
    vecs.push_back(mk(0, 0, 0, '0, 1, 0, 7, '0, 2));
    for (int i = 0; i < 2; i++) vecs.push_back(idle());
    for (int a = 0; a < DEPTH; a++) vecs.push_back(mk(0, 0, 0, '0, 1, 0, a, '0, 2));
    for (int i = 0; i < 4; i++) vecs.push_back(idle());

    // Reset state; ready follows valid even while reset is held
    req1_valid_i = 1'b1;
    #2;
    checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b1 || bram_en_o !== 1'b0 ||
        bram_we_o !== 1'b0 || bram_addr_o !== '0 || bram_din_o !== '0 ||
        bram_regce_o !== 1'b0 || rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0 ||
        bram_rstn_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: r0=%b r1=%b en=%b we=%b addr=%h din=%h regce=%b rv0=%b rv1=%b rstn=%b, want 0 1 0 0 0 0 0 0 0 0",
               req0_ready_o, req1_ready_o, bram_en_o, bram_we_o, bram_addr_o,
               bram_din_o, bram_regce_o, rsp0_valid_o, rsp1_valid_o, bram_rstn_o);
    end
    req1_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (bram_rstn_o !== 1'b1) begin
      errors++;
      $display("FAIL rstn_release: got %b want 1", bram_rstn_o);
    end
    @(posedge clk_i);
    #1;

    // Preload: req0 alone writes 0x11*a everywhere (leaves pointer at 1)
    for (int a = 0; a < DEPTH; a++)
      step(mk(1, 1, a, RAM_WIDTH'(32'h11 * a), 0, 0, 0, '0, 1));
    step(idle());

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-flight: two reads transfer, then reset before any returns
    step(mk(0, 0, 0, '0, 1, 0, 2, '0, 2));                    // pointer -> 0
    step(mk(1, 0, 1, '0, 1, 0, 2, '0, 1));                    // pointer -> 1
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    rst_i        = 1'b1;
    exp_q.delete();
    last_addr    = '0;
    last_din     = '0;
    #1;
    checks++;
    if (bram_en_o !== 1'b0 || bram_regce_o !== 1'b0 || bram_addr_o !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got en=%b regce=%b addr=%h, want 0 0 0",
               bram_en_o, bram_regce_o, bram_addr_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(mk(1, 0, 4, '0, 1, 0, 9, '0, 1));                    // pointer back at 0
    for (int i = 0; i < 3; i++) step(idle());

    // Hold stability: req1 loses a tie, holds its payload, wins next cycle
    step(mk(0, 0, 0, '0, 1, 0, 6, '0, 2));                    // pointer -> 0
    step(mk(1, 0, 4, '0, 1, 0, 9, '0, 1));
    step(mk(0, 0, 0, '0, 1, 0, 9, '0, 2));
    for (int i = 0; i < 5; i++) step(idle());

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lut_bram_port_arbiter.md
# lut_bram_port_arbiter

Round-robin arbiter that shares one port of the engine's true-dual-port, no-change, 2-cycle-read-latency LUT BRAM between two requesters: the coefficient loader (writes and readback) and the approximation datapath (reads). It registers the BRAM port command, tracks the read pipeline, and routes each read result back to its issuer. It sits between the requesters and port A or port B of the BRAM. The other BRAM port stays under independent control.

## Interface
Parameters:
- RAM_WIDTH, 32, BRAM data width
- ADDR_LINES, 4, BRAM address bits

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i / req1_valid_i  in  1  request valid, requester 0 / 1
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- req0_we_i / req1_we_i  in  1  1 = write, 0 = read
- req0_addr_i / req1_addr_i  in  ADDR_LINES  address
- req0_wdata_i / req1_wdata_i  in  RAM_WIDTH  write data
- rsp0_valid_o / rsp1_valid_o  out  1  read data valid for requester 0 / 1
- rsp_data_o  out  RAM_WIDTH  read data, shared by both requesters; qualified by rspN_valid_o
- bram_en_o  out  1  to BRAM port enable
- bram_we_o  out  1  to BRAM port write enable
- bram_addr_o  out  ADDR_LINES  to BRAM port address
- bram_din_o  out  RAM_WIDTH  to BRAM port write data
- bram_regce_o  out  1  to BRAM port output register enable
- bram_rstn_o  out  1  to BRAM port output reset (active-low); equals ~rst_i
- bram_dout_i  in  RAM_WIDTH  from BRAM port output data

## Operation
- A request transfers on a rising edge when reqN_valid_i and reqN_ready_o are both 1.
- reqN_ready_o is combinational from the valids and the priority pointer:
  - Only one valid: that requester gets ready.
  - Both valid: the requester named by the priority pointer gets ready.
  - At most one ready is high per cycle.
  - Ready depends on valid, so requesters must not make valid depend on ready.
- Valid/payload rule: once valid is raised, the requester holds valid and payload stable until the transfer.
- Priority pointer:
  - Resets to 0.
  - After any transfer it points to the requester that was not granted.
- Command register, loaded at the transfer edge:
  - bram_en_o = 1; bram_we_o, bram_addr_o and bram_din_o take the granted request's values.
  - With no transfer, bram_en_o = 0 and bram_we_o = 0; addr and din hold their previous values.
- Read tracking uses a 2-stage pipeline of {valid, id}:
  - s1 loads {en & ~we, granted id} from the command register.
  - s2 loads from s1.
  - bram_regce_o = s1.valid.
  - rspN_valid_o = s2.valid & (s2.id == N).
  - rsp_data_o = bram_dout_i (passthrough).
- Writes produce no response. Write completion is implied by the transfer.
- Throughput is one request per cycle, reads and writes mixed back to back.
- Responses return in issue order and cannot be back-pressured; requesters must always accept them.
- Ordering guarantee: a read transferred any cycle after a write to the same address returns the new data.

## Timing
- Reset values: reqN_ready_o follows the valids combinationally. All other outputs are 0: bram_en_o, bram_we_o, bram_addr_o, bram_din_o, bram_regce_o, rsp0_valid_o, rsp1_valid_o. Pointer and pipeline are 0.
- Read latency:
  - Transfer at edge E0 drives bram_en_o during cycle E0..E1.
  - The BRAM internal read register loads at E1.
  - bram_regce_o is high during E1..E2; the BRAM output register loads at E2.
  - rspN_valid_o and rsp_data_o are valid during E2..E3, i.e. 3 edges after the transfer edge counting E0.
- Simultaneous valids alternate grants every cycle: 0, 1, 0, 1 …
- A lone requester gets a grant every cycle, regardless of the pointer.
- Reset asserted mid-operation:
  - The command register and s1/s2 clear immediately.
  - In-flight reads are dropped and no rspN_valid_o is produced for them.
  - A write already presented to the BRAM before the reset edge may or may not commit; software reloads after reset.
- Address wrap is not handled; addresses are used as given, and the full range 0..2^ADDR_LINES-1 is legal.

## Test plan
- Single read:
  - Preload addr 3 = 0xDEADBEEF through req0 write.
  - req0 read addr 3 at E0 -> rsp0_valid_o = 1 only during E2..E3 with rsp_data_o = 0xDEADBEEF; rsp1_valid_o stays 0.
- Contention:
  - Both requesters hold valid reads for 6 cycles: req0 to addr 1 (=0x11), req1 to addr 2 (=0x22).
  - Required: grants alternate 0,1,0,1,0,1; responses alternate 0x11 on rsp0 and 0x22 on rsp1, one per cycle, each 3 edges after its grant.
- Write then read back-to-back:
  - req0 writes 0xA5A5A5A5 to addr 7; req1 reads addr 7 the next cycle.
  - Required: rsp1 data = 0xA5A5A5A5.
- Lone requester streaming:
  - req1 reads addrs 0..15 continuously -> 16 consecutive rsp1_valid_o cycles with data matching the preloaded pattern, and no bubbles.
- Reset mid-flight:
  - Assert rst_i one cycle after two reads transfer -> rsp0_valid_o and rsp1_valid_o are never asserted.
  - After release, the pointer is 0: with both valid, req0 is granted first.
- Hold stability:
  - req1 valid while req0 holds priority -> req1 payload is held and granted the next cycle.
  - Required: exactly one transfer per request; no duplicate response.
